// File: rtl/pipe_divider.sv
// Iterative 32-bit radix-2 restoring divider for MIPS DIV/DIVU.
// Produces quotient (LO) and remainder (HI) after a fixed 34-cycle latency.
module pipe_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        cancel_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o
);

    // Handshake: start_i is accepted only on an edge where busy_o is low and
    // cancel_i is low; the result is valid from the done_o pulse until the
    // next done_o. start_i while busy is ignored, never queued.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        load;
    logic        step;
    logic        finish;

    logic [5:0]  cnt;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dvs;
    logic [31:0] dividend_raw;
    logic        neg_q;
    logic        neg_r;
    logic        div_zero;

    logic        dividend_neg;
    logic        divisor_neg;
    logic [31:0] dividend_mag;
    logic [31:0] divisor_mag;

    logic [32:0] shifted;
    logic        fits;
    logic [31:0] diff;

    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_i && !cancel_i) begin
                    load       = 1'b1;
                    state_next = ITER;
                end
            end
            ITER: begin
                if (cancel_i) begin
                    state_next = IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == 6'd31) begin
                        state_next = FIX;
                    end
                end
            end
            FIX: begin
                state_next = IDLE;
                if (!cancel_i) begin
                    finish = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // 0x80000000 negates to itself, which read unsigned is exactly 2^31.
    always_comb begin
        dividend_neg = signed_i & dividend_i[31];
        divisor_neg  = signed_i & divisor_i[31];
        dividend_mag = dividend_neg ? (32'd0 - dividend_i) : dividend_i;
        divisor_mag  = divisor_neg  ? (32'd0 - divisor_i)  : divisor_i;
    end

    // Partial remainder stays below the divisor, so 32 bits hold it; the
    // shifted-out bit only takes part in the trial comparison.
    always_comb begin
        shifted = {rem, quo[31]};
        fits    = (shifted >= {1'b0, dvs});
        diff    = shifted[31:0] - dvs;
    end

    always_comb begin
        quo_fix = neg_q ? (32'd0 - quo) : quo;
        rem_fix = neg_r ? (32'd0 - rem) : rem;
        if (div_zero) begin
            quo_fix = 32'hFFFF_FFFF;
            rem_fix = dividend_raw;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 6'd0;
            rem          <= 32'd0;
            quo          <= 32'd0;
            dvs          <= 32'd0;
            dividend_raw <= 32'd0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            div_zero     <= 1'b0;
            done_o       <= 1'b0;
            quotient_o   <= 32'd0;
            remainder_o  <= 32'd0;
        end else begin
            state  <= state_next;
            done_o <= finish;
            if (load) begin
                cnt          <= 6'd0;
                rem          <= 32'd0;
                quo          <= dividend_mag;
                dvs          <= divisor_mag;
                dividend_raw <= dividend_i;
                neg_q        <= dividend_neg ^ divisor_neg;
                neg_r        <= dividend_neg;
                div_zero     <= (divisor_i == 32'd0);
            end
            if (step) begin
                cnt <= cnt + 6'd1;
                rem <= fits ? diff : shifted[31:0];
                quo <= {quo[30:0], fits};
            end
            if (finish) begin
                quotient_o  <= quo_fix;
                remainder_o <= rem_fix;
            end
        end
    end

    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_pipe_divider.sv
// Directed bench for pipe_divider: latency, signed/unsigned results, edge
// operands, cancel, ignored start, reset and back-to-back issue.
module tb_pipe_divider;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic        signed_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        cancel_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] quotient_o;
    logic [31:0] remainder_o;

    int checks;
    int errors;

    pipe_divider dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .signed_i    (signed_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .cancel_i    (cancel_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .quotient_o  (quotient_o),
        .remainder_o (remainder_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge right after the start edge.
    task automatic start_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        start_i    = 1'b1;
        signed_i   = s;
        dividend_i = a;
        divisor_i  = b;
        @(negedge clk);
        start_i    = 1'b0;
        dividend_i = $urandom;
        divisor_i  = $urandom;
    endtask

    // Latency is counted in cycles from the cycle start_i was presented;
    // -1 means done_o never arrived within the budget.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = -1;
        busy_cnt = 0;
        for (int k = 0; k < 45; k++) begin
            if (done_o) begin
                lat = k + 1;
                break;
            end
            if (busy_o) busy_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({busy_o, done_o, quotient_o, remainder_o} !== 66'd0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b done=%b q=%h r=%h required all 0",
                     busy_o, done_o, quotient_o, remainder_o);
        end
    endtask

    task automatic test_div(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic s, input logic [31:0] exp_q, input logic [31:0] exp_r);
        int lat;
        int bc;
        start_div(a, b, s);
        wait_done(lat, bc);
        checks++;
        if (lat !== 34) begin
            errors++;
            $display("FAIL %s_latency got %0d required 34", name, lat);
        end
        checks++;
        if (bc !== 33) begin
            errors++;
            $display("FAIL %s_busy_cycles got %0d required 33", name, bc);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_at_done got %b required 0", name, busy_o);
        end
        checks++;
        if (quotient_o !== exp_q || remainder_o !== exp_r) begin
            errors++;
            $display("FAIL %s_result q=%h r=%h required q=%h r=%h",
                     name, quotient_o, remainder_o, exp_q, exp_r);
        end
        @(negedge clk);
        checks++;
        if (done_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_width got %b required 0 one cycle later", name, done_o);
        end
    endtask

    task automatic test_cancel();
        int lat;
        int bc;
        logic saw_done;
        test_div("pre_cancel", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
        start_div(32'd50, 32'd3, 1'b0);
        repeat (4) @(negedge clk);
        start_i    = 1'b1;
        dividend_i = 32'd9;
        divisor_i  = 32'd2;
        @(negedge clk);
        start_i    = 1'b0;
        repeat (4) @(negedge clk);
        cancel_i = 1'b1;
        @(negedge clk);
        cancel_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL cancel_busy got %b required 0", busy_o);
        end
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done_o || busy_o) saw_done = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL cancel_quiet got activity=%b required 0", saw_done);
        end
        checks++;
        if (quotient_o !== 32'd14 || remainder_o !== 32'd2) begin
            errors++;
            $display("FAIL cancel_hold q=%h r=%h required q=0000000e r=00000002",
                     quotient_o, remainder_o);
        end
        test_div("after_cancel", 32'd9, 32'd2, 1'b0, 32'd4, 32'd1);
        lat = 0;
        bc  = 0;
    endtask

    task automatic test_reset_busy();
        logic saw;
        start_div(32'd1000, 32'd10, 1'b0);
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({busy_o, done_o, quotient_o, remainder_o} !== 66'd0) begin
            errors++;
            $display("FAIL reset_busy_outputs busy=%b done=%b q=%h r=%h required all 0",
                     busy_o, done_o, quotient_o, remainder_o);
        end
        saw = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done_o || busy_o) saw = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (saw !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_quiet got activity=%b required 0", saw);
        end
        start_i  = 1'b1;
        cancel_i = 1'b1;
        @(negedge clk);
        start_i  = 1'b0;
        cancel_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL start_with_cancel_busy got %b required 0", busy_o);
        end
        test_div("after_reset", 32'd9, 32'd2, 1'b0, 32'd4, 32'd1);
    endtask

    task automatic test_back_to_back();
        int lat;
        int bc;
        start_div(32'd1000, 32'd10, 1'b0);
        wait_done(lat, bc);
        checks++;
        if (lat !== 34 || quotient_o !== 32'd100 || remainder_o !== 32'd0) begin
            errors++;
            $display("FAIL b2b_first lat=%0d q=%h r=%h required lat=34 q=00000064 r=00000000",
                     lat, quotient_o, remainder_o);
        end
        start_div(32'hFFFF_FF9C, 32'd7, 1'b1);
        wait_done(lat, bc);
        checks++;
        if (lat !== 34 || quotient_o !== 32'hFFFF_FFF2 || remainder_o !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL b2b_second lat=%0d q=%h r=%h required lat=34 q=fffffff2 r=fffffffe",
                     lat, quotient_o, remainder_o);
        end
        @(negedge clk);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        start_i    = 1'b0;
        signed_i   = 1'b0;
        dividend_i = 32'd0;
        divisor_i  = 32'd0;
        cancel_i   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_div("udiv_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
        test_div("sdiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        test_div("sdiv_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1);
        test_div("udiv_big_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1);
        test_div("udiv_by_0", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5);
        test_div("sdiv_by_0", 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5);
        test_div("sdiv_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
        test_cancel();
        test_reset_busy();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
